trigger_capture: RTL
====================

// Module: trigger_capture
// PURPOSE
//  Parametrised edge-trigger and capture engine for the scope datapath: decimates the ADC stream,
//  detects a level crossing with hysteresis, and stores a DEPTH-sample window with PRE_TRIG samples
//  before the trigger. The display side reads the frozen window through a random-access port.
//  Sits between the ADC sample interface and the waveform renderer.
// PARAMETERS
//  DATA_W    12    sample/level width (unsigned ADC codes)
//  DEPTH     256   capture window length; power of two
//  PRE_TRIG  64    samples kept before the trigger sample; 0..DEPTH-1
//  MID_CODE  2054  ADC code of 0 V, added to level
//  HYST      40    hysteresis in codes between arm and fire thresholds
//  LVL_OFS   8     fixed offset subtracted from the threshold
//  DECIM_W   12    width of decimation divider
//  TMO_W     16    width of auto-mode timeout counter
// PORTS
//  clk           in   1                single system clock
//  rst_n         in   1                reset; asynchronous, active-low
//  sample_valid  in   1                sample is valid this cycle
//  sample        in   DATA_W           ADC code
//  level         in   DATA_W           user trigger level (code above MID_CODE)
//  decim_max     in   DECIM_W          keep 1 of (decim_max+1) valid samples
//  edge_sel      in   1                0 rising, 1 falling
//  mode          in   2                0 NORMAL, 1 AUTO, 2 SINGLE, 3 = NORMAL
//  arm           in   1                pulse: restart capture from any state
//  auto_tmo      in   TMO_W            AUTO: accepted samples in ARMED before forced trigger
//  trig_allow    in   1                trigger may fire only while high (display blanking)
//  done_ack      in   1                pulse: display finished reading window
//  rd_addr       in   $clog2(DEPTH)    window index, 0 = oldest pre-trigger sample
//  rd_data       out  DATA_W           window sample, registered, 1-cycle latency
//  capture_done  out  1                window frozen and readable (level)
//  forced        out  1                last window produced by AUTO timeout, not an edge
//  busy          out  1                high in PRE_FILL/ARMED/HYST/POST
// BEHAVIOUR
//  Reset: state IDLE, all counters/pointers 0, capture_done=0, forced=0, busy=0, rd_data=0.
//  Decimation: div_cnt increments on sample_valid; accept when div_cnt==decim_max, then div_cnt<=0.
//   decim_max=0 accepts every valid sample. Only accepted samples advance the FSM or memory.
//  Threshold: thr = MID_CODE+level-LVL_OFS, computed in DATA_W+2 bits signed; compare extended, no wrap.
//   Rising: arm when sample<thr; fire when sample>=thr+HYST. Falling: arm when sample>thr; fire sample<=thr-HYST.
//  FSM (trigger_pkg::state_t):
//   IDLE     -> PRE_FILL after reset release or arm.
//   PRE_FILL write; after PRE_TRIG accepted samples -> ARMED (PRE_TRIG=0: direct).
//   ARMED    write; arm condition -> HYST; AUTO and tmo_cnt==auto_tmo -> POST with forced=1.
//   HYST     write; fire condition && trig_allow -> POST, trig_ptr<=wr_ptr; sample back outside arm
//            side (rising: >=thr && <thr+HYST stays; rising) never re-arms; fire without trig_allow stays HYST.
//   POST     write DEPTH-PRE_TRIG-1 more samples after trigger sample -> DONE.
//   DONE     no writes; capture_done=1. done_ack: NORMAL/AUTO -> PRE_FILL; SINGLE ignores, waits for arm.
//  arm in any state: -> PRE_FILL next cycle, counters cleared, capture_done=0, forced=0; arm wins over done_ack.
//  tmo_cnt counts accepted samples in ARMED/HYST; cleared on state entry to PRE_FILL.
//  Memory: ring, wr_ptr wraps mod DEPTH. rd_data <= mem[(trig_ptr-PRE_TRIG+rd_addr) mod DEPTH] every
//   cycle; valid only while capture_done=1. Sample at rd_addr==PRE_TRIG is the trigger sample.
//  Async reset mid-capture: immediate IDLE; memory contents undefined, capture_done=0.
// STRUCTURE
//  trigger_pkg: state_t, mode_t (NORMAL/AUTO/SINGLE), edge_t, default MID_CODE/HYST/LVL_OFS constants.
//  Sub-module trigger_ring_ram: simple dual-port RAM, 1 write port, 1 registered read port, DEPTH x DATA_W.
//  Top: decimator, threshold compare, FSM, pointer/count logic.
// TESTING
//  1 Ramp 0..4095 step 16, level=0, rising, NORMAL, trig_allow=1 -> first sample >=2086 at rd_addr 64.
//  2 Same ramp, edge_sel=1, descending 4095..0 -> rd_addr 64 holds first sample <=2006; capture_done=1.
//  3 decim_max=3, ramp step 1 -> window holds every 4th code, consecutive rd_data differ by 4.
//  4 AUTO, auto_tmo=100, constant 1000 -> capture_done after PRE_TRIG+100+191 accepted samples, forced=1.
//  5 Noise 2040..2070 around thr=2046 -> never fires in NORMAL; then step to 2100 -> fires once.
//  6 SINGLE: done_ack ignored (capture_done stays 1); arm mid-POST -> PRE_FILL, capture_done=0; rst_n low
//    mid-POST -> busy=0 same cycle.

Source files
------------

// File: rtl/trigger_pkg.sv
// ---------------------------------------------------------------------------
// trigger_pkg
// Shared types and default constants for the trigger/capture engine.
//   state_t     : capture FSM states
//   mode_t      : acquisition mode (NORMAL / AUTO / SINGLE)
//   edge_t      : trigger slope
//   decode_mode : maps the raw 2-bit mode port onto mode_t (code 3 = NORMAL)
// ---------------------------------------------------------------------------
package trigger_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_ARMED,
    S_HYST,
    S_POST,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_SINGLE = 2'd2
  } mode_t;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_t;

  localparam int MID_CODE_DEF = 2054;  // ADC code of 0 V
  localparam int HYST_DEF     = 40;    // codes between arm and fire thresholds
  localparam int LVL_OFS_DEF  = 8;     // fixed offset removed from the threshold

  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_AUTO;
      2'd2:    return MODE_SINGLE;
      default: return MODE_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/trigger_capture_if.sv
// ---------------------------------------------------------------------------
// trigger_capture_if
// ADC sample stream into the trigger engine.
//   sample_valid : sample is valid this cycle
//   sample       : unsigned ADC code
// master = ADC side (drives), slave = trigger engine (receives).
// ---------------------------------------------------------------------------
interface trigger_capture_if #(
  parameter int DATA_W = 12
);

  logic              sample_valid;
  logic [DATA_W-1:0] sample;

  modport master (output sample_valid, output sample);
  modport slave  (input  sample_valid, input  sample);

endinterface

// File: rtl/trigger_ring_ram.sv
// ---------------------------------------------------------------------------
// trigger_ring_ram
// Simple dual-port RAM holding the capture ring: one write port, one
// registered read port, DEPTH x DATA_W.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address, sampled every cycle
//   rdata      : read data, 1-cycle latency
// ---------------------------------------------------------------------------
module trigger_ring_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it can map onto block RAM; its
  // contents are only meaningful once a full window has been written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: sequential state is always updated with non-blocking assignments
  // so every register samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/trigger_capture.sv
// ---------------------------------------------------------------------------
// trigger_capture
// Edge-trigger and capture engine: decimates the ADC stream, detects a level
// crossing with hysteresis and freezes a DEPTH-sample window holding PRE_TRIG
// samples before the trigger sample. The display reads the frozen window
// through a random-access port.
//   clk, rst_n   : clock, async active-low reset
//   smp          : ADC sample stream (slave modport)
//   level        : trigger level, codes above MID_CODE
//   decim_max    : keep 1 of (decim_max+1) valid samples
//   edge_sel     : 0 rising, 1 falling
//   mode         : 0 NORMAL, 1 AUTO, 2 SINGLE, 3 NORMAL
//   arm          : pulse, restart capture from any state
//   auto_tmo     : AUTO: accepted samples in ARMED/HYST before forced trigger
//   trig_allow   : trigger may fire only while high
//   done_ack     : pulse, display finished reading the window
//   rd_addr      : window index, 0 = oldest pre-trigger sample
//   rd_data      : window sample, 1-cycle latency
//   capture_done : window frozen and readable
//   forced       : last window came from the AUTO timeout
//   busy         : capture in progress (PRE_FILL/ARMED/HYST/POST)
// ---------------------------------------------------------------------------
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64,
  parameter int MID_CODE = MID_CODE_DEF,
  parameter int HYST     = HYST_DEF,
  parameter int LVL_OFS  = LVL_OFS_DEF,
  parameter int DECIM_W  = 12,
  parameter int TMO_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  trigger_capture_if.slave         smp,
  input  logic [DATA_W-1:0]        level,
  input  logic [DECIM_W-1:0]       decim_max,
  input  logic                     edge_sel,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic [TMO_W-1:0]         auto_tmo,
  input  logic                     trig_allow,
  input  logic                     done_ack,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     capture_done,
  output logic                     forced,
  output logic                     busy
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CMP_W  = DATA_W + 2;           // signed, wide enough for thr +/- HYST
  localparam int POST_N = DEPTH - PRE_TRIG - 1; // samples written after the trigger sample

  localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);

  localparam logic signed [CMP_W-1:0] MID_S  = CMP_W'(MID_CODE);
  localparam logic signed [CMP_W-1:0] OFS_S  = CMP_W'(LVL_OFS);
  localparam logic signed [CMP_W-1:0] HYST_S = CMP_W'(HYST);

  // With no pre-trigger history the fill phase is skipped entirely, and with
  // no post-trigger samples the trigger sample completes the window.
  localparam state_t FILL_ENTRY = (PRE_TRIG == 0) ? S_ARMED : S_PRE_FILL;
  localparam state_t TRIG_NEXT  = (POST_N == 0)   ? S_DONE  : S_POST;

  state_t             state;
  mode_t              mode_d;
  logic [DECIM_W-1:0] div_cnt;
  logic [AW-1:0]      wr_ptr, trig_ptr, pre_cnt, post_cnt, rd_ptr;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;

  logic signed [CMP_W-1:0] smp_s, thr, thr_hi, thr_lo;
  logic falling, accept, arm_hit, fire_hit, auto_hit, trig_now, restart, we;

  // NOTE: every always_comb output is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    mode_d  = decode_mode(mode);
    falling = (edge_t'(edge_sel) == EDGE_FALL);

    // Threshold arithmetic is done sign-extended so thr - HYST near code 0 and
    // thr + HYST near full scale compare correctly instead of wrapping.
    smp_s  = $signed({2'b00, smp.sample});
    thr    = $signed({2'b00, level}) + MID_S - OFS_S;
    thr_hi = thr + HYST_S;
    thr_lo = thr - HYST_S;

    arm_hit  = falling ? (smp_s > thr) : (smp_s < thr);
    fire_hit = (falling ? (smp_s <= thr_lo) : (smp_s >= thr_hi)) && trig_allow;

    accept = smp.sample_valid && (div_cnt == decim_max);

    // The auto_tmo-th accepted sample after arming becomes the forced
    // trigger sample.
    tmo_nxt  = tmo_cnt + TMO_W'(1);
    auto_hit = (mode_d == MODE_AUTO) && (tmo_nxt == auto_tmo);

    // An edge trigger takes precedence over a timeout on the same sample.
    trig_now = accept && (((state == S_HYST) && fire_hit) || auto_hit);

    // arm wins over done_ack; SINGLE mode only leaves DONE through arm.
    restart = arm || (state == S_IDLE) ||
              ((state == S_DONE) && done_ack && (mode_d != MODE_SINGLE));

    we = accept && !restart &&
         (state inside {S_PRE_FILL, S_ARMED, S_HYST, S_POST});

    rd_ptr = trig_ptr - AW'(PRE_TRIG) + rd_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      wr_ptr       <= '0;
      trig_ptr     <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      tmo_cnt      <= '0;
      capture_done <= 1'b0;
      forced       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (arm)                   div_cnt <= '0;
      else if (smp.sample_valid) div_cnt <= (div_cnt == decim_max) ? '0 : div_cnt + DECIM_W'(1);

      if (restart) begin
        state        <= FILL_ENTRY;
        wr_ptr       <= '0;
        trig_ptr     <= '0;
        pre_cnt      <= '0;
        post_cnt     <= '0;
        tmo_cnt      <= '0;
        capture_done <= 1'b0;
        forced       <= 1'b0;
        busy         <= 1'b1;
      end else begin
        if (we) wr_ptr <= wr_ptr + AW'(1);

        case (state)
          S_PRE_FILL: begin
            if (accept) begin
              pre_cnt <= pre_cnt + AW'(1);
              if (pre_cnt == PRE_LAST) state <= S_ARMED;
            end
          end

          S_ARMED, S_HYST: begin
            if (accept) tmo_cnt <= tmo_nxt;
            if (trig_now) begin
              state    <= TRIG_NEXT;
              trig_ptr <= wr_ptr;
              forced   <= !((state == S_HYST) && fire_hit);
              if (TRIG_NEXT == S_DONE) begin
                capture_done <= 1'b1;
                busy         <= 1'b0;
              end
            end else if (accept && (state == S_ARMED) && arm_hit) begin
              // Once in HYST the engine only waits for the fire threshold;
              // wandering back between the thresholds never re-arms.
              state <= S_HYST;
            end
          end

          S_POST: begin
            if (accept) begin
              post_cnt <= post_cnt + AW'(1);
              if (post_cnt == POST_LAST) begin
                state        <= S_DONE;
                capture_done <= 1'b1;
                busy         <= 1'b0;
              end
            end
          end

          S_DONE: ;  // window frozen; leaves only through restart

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  trigger_ring_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (smp.sample),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
